// File: rtl/mips_mc_control_fsm_if.sv
// rtl/mips_mc_control_fsm_if.sv - control sequencer to datapath/memory signal bundle
interface mips_mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_we;
  logic             pc_we;
  logic             branch;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             rf_we;
  logic             rfd_sel;
  logic             mem_to_reg;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, branch, pc_src, alu_src_a,
           alu_src_b, alu_op, rf_we, rfd_sel, mem_to_reg, retire, illegal,
           instr_count, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, branch, pc_src, alu_src_a,
           alu_src_b, alu_op, rf_we, rfd_sel, mem_to_reg, retire, illegal,
           instr_count, state
  );
endinterface

// File: rtl/mips_mc_control_fsm.sv
// rtl/mips_mc_control_fsm.sv - multicycle MIPS control sequencer with retire counter
module mips_mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  mips_mc_control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      if (w_retire) r_count <= r_count + CNT_W'(1);
      case (r_state)
        S_FETCH:    if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        // lw and sw differ only in opcode bit 3
        S_MEMADR:   r_state <= bus.opcode[3] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (bus.mem_ready) r_state <= S_FETCH;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ADDIEX:   r_state <= S_ADDIWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the current state; reset low forces every output to zero
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.branch     = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.rf_we      = 1'b0;
    bus.rfd_sel    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;
    w_retire       = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_we     = bus.mem_ready;
          bus.pc_we     = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          bus.illegal   = !(bus.opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
        end
        S_MEMADR, S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        S_MEMWB: begin
          bus.rf_we      = 1'b1;
          bus.mem_to_reg = 1'b1;
          w_retire       = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.iord    = 1'b1;
          w_retire    = bus.mem_ready;
        end
        S_EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_ALUWB: begin
          bus.rf_we   = 1'b1;
          bus.rfd_sel = 1'b1;
          w_retire    = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b01;
          bus.pc_src    = 2'b01;
          bus.branch    = 1'b1;
          w_retire      = 1'b1;
        end
        S_ADDIWB: begin
          bus.rf_we = 1'b1;
          w_retire  = 1'b1;
        end
        S_JUMP: begin
          bus.pc_src = 2'b10;
          bus.pc_we  = 1'b1;
          w_retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.retire      = w_retire;
  assign bus.instr_count = rst ? r_count : '0;
  assign bus.state       = rst ? r_state : 4'd0;
endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// tb/tb_mips_mc_control_fsm.sv - scoreboard bench for the multicycle control sequencer
module tb_mips_mc_control_fsm;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mips_mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  mips_mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstv;
    logic        rdy;
    logic [5:0]  opc;
    logic [21:0] exp;
  } sb_t;

  sb_t             sb[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              n_ret_seen = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  function automatic logic [21:0] exp_out(input logic [3:0] st, input logic rdy, input logic [5:0] opc);
    logic mreq, mwe, io, irwe, pcwe, br, asa, rfwe, rfd, m2r, ret, ill;
    logic [1:0] pcs, bsrc, aop;
    {mreq, mwe, io, irwe, pcwe, br, asa, rfwe, rfd, m2r, ret, ill} = '0;
    pcs = 2'b00; bsrc = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mreq = 1; bsrc = 2'b01; irwe = rdy; pcwe = rdy; end
      4'd1:  begin bsrc = 2'b11; ill = !(opc inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}); end
      4'd2:  begin asa = 1; bsrc = 2'b10; end
      4'd3:  begin mreq = 1; io = 1; end
      4'd4:  begin rfwe = 1; m2r = 1; ret = 1; end
      4'd5:  begin mreq = 1; mwe = 1; io = 1; ret = rdy; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rfwe = 1; rfd = 1; ret = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; ret = 1; end
      4'd9:  begin asa = 1; bsrc = 2'b10; end
      4'd10: begin rfwe = 1; ret = 1; end
      4'd11: begin pcs = 2'b10; pcwe = 1; ret = 1; end
      default: ;
    endcase
    return {st, mreq, mwe, io, irwe, pcwe, br, pcs, asa, bsrc, aop, rfwe, rfd, m2r, ret, ill};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.branch,
            bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.rf_we, bus.rfd_sel,
            bus.mem_to_reg, bus.retire, bus.illegal};
  endfunction

  function automatic void push_cycle(input logic rstv, input logic rdy, input logic [5:0] opc, input logic [3:0] st);
    sb_t e;
    e.rstv = rstv;
    e.rdy  = rdy;
    e.opc  = opc;
    e.exp  = rstv ? exp_out(st, rdy, opc) : 22'd0;
    sb.push_back(e);
  endfunction

  function automatic logic nz(input logic noise);
    return noise ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  function automatic void push_instr(input logic [5:0] opc, input int fw, input int mw, input logic noise);
    for (int i = 0; i < fw; i++) push_cycle(1, 0, opc, 4'd0);
    push_cycle(1, 1, opc, 4'd0);
    push_cycle(1, nz(noise), opc, 4'd1);
    case (opc)
      OP_LW: begin
        push_cycle(1, nz(noise), opc, 4'd2);
        for (int i = 0; i < mw; i++) push_cycle(1, 0, opc, 4'd3);
        push_cycle(1, 1, opc, 4'd3);
        push_cycle(1, nz(noise), opc, 4'd4);
      end
      OP_SW: begin
        push_cycle(1, nz(noise), opc, 4'd2);
        for (int i = 0; i < mw; i++) push_cycle(1, 0, opc, 4'd5);
        push_cycle(1, 1, opc, 4'd5);
      end
      OP_R: begin
        push_cycle(1, nz(noise), opc, 4'd6);
        push_cycle(1, nz(noise), opc, 4'd7);
      end
      OP_ADDI: begin
        push_cycle(1, nz(noise), opc, 4'd9);
        push_cycle(1, nz(noise), opc, 4'd10);
      end
      OP_BEQ: push_cycle(1, nz(noise), opc, 4'd8);
      OP_J:   push_cycle(1, nz(noise), opc, 4'd11);
      default: ;
    endcase
  endfunction

  task automatic run_queue(input string name);
    sb_t e;
    logic [CNT_W-1:0] exp_cnt;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst = e.rstv;
      bus.mem_ready = e.rdy;
      bus.opcode = e.opc;
      #1;
      n_tests++;
      if (dut_vec() !== e.exp) begin
        n_fail++;
        $display("FAIL %s outputs: got %h expected %h (state got %0d expected %0d)",
                 name, dut_vec(), e.exp, bus.state, e.exp[21:18]);
      end
      exp_cnt = e.rstv ? model_cnt : '0;
      n_tests++;
      if (bus.instr_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s instr_count: got %0d expected %0d", name, bus.instr_count, exp_cnt);
      end
      if (bus.retire === 1'b1) n_ret_seen++;
      if (!e.rstv) model_cnt = '0;
      else if (e.exp[1]) model_cnt = model_cnt + 1'b1;
    end
  endtask

  task automatic check_retires(input string name, input int expected);
    n_tests++;
    if (n_ret_seen !== expected) begin
      n_fail++;
      $display("FAIL %s retire pulses: got %0d expected %0d", name, n_ret_seen, expected);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) push_cycle(0, 1, OP_R, 4'd0);
    push_cycle(1, 0, OP_R, 4'd0);
    run_queue("reset");
  endtask

  task automatic test_zero_wait();
    n_ret_seen = 0;
    push_instr(OP_LW, 0, 0, 0);
    push_instr(OP_SW, 0, 0, 0);
    push_instr(OP_R, 0, 0, 0);
    push_instr(OP_ADDI, 0, 0, 0);
    push_instr(OP_BEQ, 0, 0, 0);
    push_instr(OP_J, 0, 0, 0);
    push_cycle(1, 0, OP_R, 4'd0);
    run_queue("zero_wait");
    check_retires("zero_wait", 6);
    n_tests++;
    if (bus.instr_count !== 4'd6) begin
      n_fail++;
      $display("FAIL zero_wait final count: got %0d expected 6", bus.instr_count);
    end
  endtask

  task automatic test_wait_states();
    n_ret_seen = 0;
    push_instr(OP_LW, 2, 3, 0);
    push_cycle(1, 0, OP_R, 4'd0);
    run_queue("wait_states");
    check_retires("wait_states", 1);
  endtask

  task automatic test_illegal();
    n_ret_seen = 0;
    push_instr(6'b111111, 0, 0, 1);
    push_instr(6'b000001, 1, 0, 1);
    push_cycle(1, 0, OP_R, 4'd0);
    run_queue("illegal");
    check_retires("illegal", 0);
  endtask

  task automatic test_wrap();
    n_ret_seen = 0;
    for (int i = 0; i < 16; i++) push_instr(OP_R, 0, 0, 1);
    push_cycle(1, 0, OP_R, 4'd0);
    run_queue("wrap");
    check_retires("wrap", 16);
  endtask

  task automatic test_reset_mid_write();
    n_ret_seen = 0;
    push_cycle(1, 1, OP_SW, 4'd0);
    push_cycle(1, 1, OP_SW, 4'd1);
    push_cycle(1, 1, OP_SW, 4'd2);
    push_cycle(1, 0, OP_SW, 4'd5);
    push_cycle(1, 0, OP_SW, 4'd5);
    push_cycle(0, 0, OP_SW, 4'd5);
    push_cycle(1, 0, OP_SW, 4'd0);
    push_cycle(1, 1, OP_SW, 4'd0);
    push_cycle(1, 1, OP_SW, 4'd1);
    run_queue("reset_mid_write");
    check_retires("reset_mid_write", 0);
    sb.delete();
    push_cycle(1, 1, OP_SW, 4'd2);
    push_cycle(1, 1, OP_SW, 4'd5);
    push_cycle(1, 0, OP_R, 4'd0);
    run_queue("after_reset_sw");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_ADDI; ops[4] = OP_BEQ; ops[5] = OP_J;
    for (int i = 0; i < 12; i++)
      push_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2), 1);
    push_cycle(1, 0, OP_R, 4'd0);
    run_queue("back_to_back");
  endtask

  initial begin
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_illegal();
    test_wrap();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
